// File: rtl/serial_parity_checker_pkg.sv
// Types and helpers shared by the serial parity checker and its sub-modules.
package serial_parity_checker_pkg;

`include "serial_parity_defs.vh"

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_DATA = ST_DATA,
      S_PAR  = ST_PAR
   } state_t;

   // A frame is in error when its total parity differs from the selected mode.
   function automatic logic frame_error(input logic total_par, input logic odd_mode);
      return total_par ^ odd_mode;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a coincident increment wins over clear.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   // Count events, stick at all-ones, clear to 0 (or 1 if an event lands on the clear).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= inc ? CNT_W'(1) : '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/serial_parity_defs.vh
// Shared encodings for the serial parity checker: FSM state codes and parity modes.
`ifndef SERIAL_PARITY_DEFS_VH
`define SERIAL_PARITY_DEFS_VH

localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_DATA = 2'd1;
localparam logic [1:0] ST_PAR  = 2'd2;

localparam int PAR_MODE_EVEN = 0;
localparam int PAR_MODE_ODD  = 1;

`endif

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: sof-marked data bits (LSB first) followed by one parity bit.
// Tracks running parity, latches the completed word and flags/counts parity errors.
module serial_parity_checker
   import serial_parity_checker_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ODD    = 0,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              x,
   input  logic              x_valid,
   input  logic              sof,
   input  logic              clr_err,
   output logic              z,
   output logic [DATA_W-1:0] data_out,
   output logic              frame_done,
   output logic              parity_err,
   output logic              frame_abort,
   output logic [CNT_W-1:0]  err_count
);

   localparam int              BC_W     = $clog2(DATA_W + 1);
   localparam logic [BC_W-1:0] LAST_IDX = BC_W'(DATA_W - 1);
   localparam logic            ODD_BIT  = (ODD == PAR_MODE_ODD);

   state_t            r_state,   w_state_next;
   logic [BC_W-1:0]   r_bit_cnt, w_bit_cnt_next;
   logic [DATA_W-1:0] r_shift,   w_shift_next;
   logic [DATA_W-1:0] r_data,    w_data_next;
   logic              r_z,       w_z_next;
   logic              r_done,    w_done_next;
   logic              r_perr,    w_perr_next;
   logic              r_abort,   w_abort_next;
   logic              w_err_inc;

   // State and output registers; every output comes straight from a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_z       <= 1'b0;
         r_done    <= 1'b0;
         r_perr    <= 1'b0;
         r_abort   <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_shift   <= w_shift_next;
         r_data    <= w_data_next;
         r_z       <= w_z_next;
         r_done    <= w_done_next;
         r_perr    <= w_perr_next;
         r_abort   <= w_abort_next;
      end
   end

   // Next-state logic: sof always opens a new frame, otherwise advance the open frame.
   always_comb begin
      w_state_next   = r_state;
      w_bit_cnt_next = r_bit_cnt;
      w_shift_next   = r_shift;
      w_data_next    = r_data;
      w_z_next       = r_z;
      w_perr_next    = r_perr;
      w_done_next    = 1'b0;
      w_abort_next   = 1'b0;
      if (x_valid) begin
         if (sof) begin
            // Restarting an open frame discards it silently apart from the abort pulse.
            w_abort_next    = (r_state != S_IDLE);
            w_z_next        = x;
            w_shift_next    = '0;
            w_shift_next[0] = x;
            if (DATA_W == 1) begin
               w_state_next   = S_PAR;
               w_bit_cnt_next = '0;
            end else begin
               w_state_next   = S_DATA;
               w_bit_cnt_next = BC_W'(1);
            end
         end else begin
            case (r_state)
               S_DATA: begin
                  w_shift_next[r_bit_cnt] = x;
                  w_z_next                = r_z ^ x;
                  if (r_bit_cnt == LAST_IDX) begin
                     w_state_next   = S_PAR;
                     w_bit_cnt_next = '0;
                  end else begin
                     w_bit_cnt_next = r_bit_cnt + 1'b1;
                  end
               end
               S_PAR: begin
                  w_z_next       = r_z ^ x;
                  w_done_next    = 1'b1;
                  w_data_next    = r_shift;
                  w_perr_next    = frame_error(r_z ^ x, ODD_BIT);
                  w_state_next   = S_IDLE;
                  w_bit_cnt_next = '0;
               end
               default: begin
                  // Bits outside a frame are ignored until the next sof.
               end
            endcase
         end
      end
   end

   assign w_err_inc = w_done_next & w_perr_next;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_err_inc),
      .clr   (clr_err),
      .count (err_count)
   );

   assign z           = r_z;
   assign data_out    = r_data;
   assign frame_done  = r_done;
   assign parity_err  = r_perr;
   assign frame_abort = r_abort;

endmodule
